fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of ProgramCounter.
- Takes the current PC value (ProgramCounter PC_res) and issues single-word reads to instruction memory over a req/gnt/rvalid interface.
- Drives the PC increment request (ProgramCounter Inc_PC) and buffers returned instructions with their PCs in a small FIFO that the decode stage drains with a valid/ready handshake.
- A flush input discards in-flight and buffered instructions when the PC is loaded on a branch or jump.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly downstream of the
// program counter. It issues single-word reads for the current PC over a
// req/gnt/rvalid memory interface and asks the PC to advance on every accepted
// request. Returned words are buffered with their PCs in a small FIFO that
// decode drains through a valid/ready handshake. A flush throws away both the
// buffered and the in-flight instructions.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pc_addr      current PC from the program counter
//   flush        redirect, high in the cycle the PC is loaded
//   inc_pc       PC advance request, high when a read is accepted
//   imem_req     memory read request
//   imem_addr    memory read address (always equal to pc_addr)
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   instr_valid  buffer head holds an instruction
//   instr        instruction at the buffer head
//   instr_pc     PC of the instruction at the buffer head
//   instr_ready  decode accepts the head this cycle
module fetch_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              inc_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] req_pc;
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic              has_room;
  logic              push;
  logic              pop;

  assign imem_addr = pc_addr;

  // Requests are only made when a slot is free, so the response of the single
  // outstanding read always has room in the buffer.
  assign has_room = (count < FULL);
  assign imem_req = (state == S_REQ) && !flush && has_room;
  assign inc_pc   = imem_req && imem_gnt;

  // A response that coincides with a flush belongs to the old path: drop it.
  assign push = (state == S_WAIT) && imem_rvalid && !flush;
  assign pop  = instr_valid && instr_ready;

  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  assign instr_valid = (count != '0);
  assign instr       = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (has_room && !flush) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (inc_pc) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // After a flush the buffer is emptied, so there is always room.
          state_nxt = (flush || (count_nxt < FULL)) ? S_REQ : S_IDLE;
        end else if (flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The stale response is still owed; swallow it before re-requesting.
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (inc_pc) req_pc <= pc_addr;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (push) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays program counter and
// instruction memory, keeps a scoreboard of instructions that decode should
// receive, and compares every pop against it.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        flush = 1'b0;
  logic        inc_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  fetch_unit #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .pc_addr(pc_addr), .flush(flush),
    .inc_pc(inc_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped_pc[$];
  int          pop_cyc[$];
  int          ntests = 0;
  int          nfail = 0;
  int          ngrant = 0;
  int          ninc = 0;
  int          cyc = 0;
  logic        outstanding = 1'b0;
  logic        drop = 1'b0;
  logic        mem_auto = 1'b0;
  logic [31:0] gpc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the scoreboard and
  // memory/PC models, then return just after the next rising edge.
  task automatic tick();
    logic was_inc;
    logic was_gnt;
    @(negedge clk);
    cyc++;
    chk("imem_addr", imem_addr, pc_addr);
    chk("inc_pc_during_flush", inc_pc && flush, 1'b0);
    chk("single_outstanding", imem_req && outstanding, 1'b0);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (instr_valid && instr_ready && q.size() != 0) begin
      chk("instr", instr, q[0].d);
      chk("instr_pc", instr_pc, q[0].p);
      popped_pc.push_back(instr_pc);
      pop_cyc.push_back(cyc);
      void'(q.pop_front());
    end
    if (imem_rvalid) begin
      if (outstanding && !drop && !flush) q.push_back(ent_t'{d: imem_rdata, p: gpc});
      outstanding = 1'b0;
      drop = 1'b0;
    end else if (flush && outstanding) begin
      drop = 1'b1;
    end
    if (flush) q.delete();
    was_gnt = imem_req && imem_gnt;
    if (was_gnt) begin
      outstanding = 1'b1;
      drop = 1'b0;
      gpc = pc_addr;
      ngrant++;
    end
    was_inc = inc_pc;
    if (inc_pc) ninc++;
    @(posedge clk);
    #1;
    if (was_inc) pc_addr = pc_addr + 32'd4;
    if (mem_auto) begin
      imem_rvalid = was_gnt;
      imem_rdata  = gpc ^ 32'hA5A5_0000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_imem_req"}, imem_req, 1'b0);
    chk({tag, "_inc_pc"}, inc_pc, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    mem_auto = 1'b0;
    q.delete();
    outstanding = 1'b0;
    drop = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values
    #1;
    check_reset_outputs("por");
    do_reset();

    // Single fetch: pc 0, data 0x13, response the cycle after grant
    pc_addr = 32'h0; imem_gnt = 1'b1; instr_ready = 1'b1;
    #1 chk("t1_idle_req", imem_req, 1'b0);
    tick();
    #1 chk("t1_req", imem_req, 1'b1);
    chk("t1_inc", inc_pc, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    #1 chk("t1_inc_pulse", inc_pc, 1'b0);
    chk("t1_not_yet_valid", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    #1 chk("t1_valid", instr_valid, 1'b1);
    chk("t1_instr", instr, 32'h13);
    chk("t1_instr_pc", instr_pc, 32'h0);
    tick();

    // Streaming with an always-granting memory
    do_reset();
    mem_auto = 1'b1; pc_addr = 32'h0; imem_gnt = 1'b1; instr_ready = 1'b1;
    popped_pc.delete(); pop_cyc.delete();
    for (int i = 0; i < 40 && popped_pc.size() < 4; i++) tick();
    chk("t2_pop_count", popped_pc.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < popped_pc.size()) chk("t2_pc_order", popped_pc[i], 32'(i * 4));
      if (i > 0 && i < pop_cyc.size()) chk("t2_gap", (pop_cyc[i] - pop_cyc[i-1]) <= 2, 1'b1);
    end
    imem_gnt = 1'b0;
    repeat (4) tick();

    // Backpressure: buffer fills, then exactly one request per pop
    do_reset();
    mem_auto = 1'b1; pc_addr = 32'h0; imem_gnt = 1'b1; instr_ready = 1'b0;
    ngrant = 0; ninc = 0;
    repeat (20) tick();
    chk("t3_grants_full", ngrant, 2);
    chk("t3_incs_full", ninc, 2);
    #1 chk("t3_req_idle", imem_req, 1'b0);
    chk("t3_inc_idle", inc_pc, 1'b0);
    chk("t3_valid_full", instr_valid, 1'b1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("t3_grants_after_pop", ngrant, 3);
    imem_gnt = 1'b0; instr_ready = 1'b1;
    repeat (6) tick();

    // Flush while a request is outstanding
    do_reset();
    pc_addr = 32'hC; imem_gnt = 1'b1; instr_ready = 1'b0;
    tick();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111;
    tick();
    imem_rvalid = 1'b0;
    #1 chk("t4_addr_10", imem_addr, 32'h10);
    chk("t4_req_10", imem_req, 1'b1);
    tick();
    imem_gnt = 1'b0; flush = 1'b1; pc_addr = 32'h100;
    #1 chk("t4_flush_req", imem_req, 1'b0);
    chk("t4_flush_inc", inc_pc, 1'b0);
    chk("t4_valid_before", instr_valid, 1'b1);
    tick();
    flush = 1'b0;
    #1 chk("t4_emptied", instr_valid, 1'b0);
    chk("t4_discard_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    #1 chk("t4_late_dropped", instr_valid, 1'b0);
    chk("t4_new_req", imem_req, 1'b1);
    chk("t4_new_addr", imem_addr, 32'h100);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0100 ^ 32'hA5A5_0000;
    tick();
    imem_rvalid = 1'b0;
    #1 chk("t4_valid", instr_valid, 1'b1);
    chk("t4_instr_pc", instr_pc, 32'h100);
    chk("t4_instr", instr, 32'hA5A5_0100);
    tick();

    // Flush together with rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
    flush = 1'b1; pc_addr = 32'h200;
    #1 chk("t5_rv_flush_inc", inc_pc, 1'b0);
    chk("t5_rv_flush_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b0; flush = 1'b0;
    #1 chk("t5_no_push", instr_valid, 1'b0);
    chk("t5_rereq", imem_req, 1'b1);
    chk("t5_rereq_addr", imem_addr, 32'h200);
    tick();

    // Flush in REQ while memory would grant
    flush = 1'b1; imem_gnt = 1'b1; pc_addr = 32'h300;
    #1 chk("t5_req_flush_req", imem_req, 1'b0);
    chk("t5_req_flush_inc", inc_pc, 1'b0);
    tick();
    flush = 1'b0;
    #1 chk("t5_target_req", imem_req, 1'b1);
    chk("t5_target_addr", imem_addr, 32'h300);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0300 ^ 32'hA5A5_0000;
    instr_ready = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    #1 chk("t5_target_pc", instr_pc, 32'h300);
    imem_gnt = 1'b1;
    tick();

    // Reset while waiting with one buffered entry, then a stray response
    imem_gnt = 1'b0;
    #1 chk("t6_buffered", instr_valid, 1'b1);
    reset_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    q.delete(); outstanding = 1'b0; drop = 1'b0;
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    repeat (3) tick();
    #1 chk("t6_stray_ignored", instr_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
